demux1to2_32_buf: RTL and testbench
===================================

DEMUX1TO2_32_BUF -- requirements
Module: demux1to2_32_buf

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 i_data  input  32  word offered by the single upstream source.
REQ-004 i_sel  input  1  destination select: 1 routes the word to port A, 0 routes it to port B.
REQ-005 i_valid  input  1  upstream word valid.
REQ-006 i_ready  output  1  block accepts the offered word this cycle.
REQ-007 a_data  output  32  head word of buffer A.
REQ-008 a_valid  output  1  buffer A is non-empty.
REQ-009 a_ready  input  1  downstream A consumes the head word.
REQ-010 b_data, b_valid, b_ready  32/1/1  same as REQ-007 to REQ-009, for port B.
REQ-011 a_cnt, b_cnt  output  16 each  count of words accepted for A and for B.

Function
REQ-012 Each of ports A and B SHALL own an independent 2-entry FIFO with in-order, 32-bit-wide storage.
REQ-013 i_ready SHALL equal "selected FIFO occupancy < 2", evaluated combinationally from i_sel and registered occupancy.
REQ-014 i_ready SHALL NOT depend on i_valid, a_ready or b_ready, so a full FIFO never accepts a word, even in the cycle it pops.
REQ-015 A push SHALL occur when i_valid && i_ready at a clk edge, writing i_data into the FIFO chosen by i_sel.
REQ-016 Push latency SHALL be 1 cycle: a word pushed at edge N is visible on x_valid/x_data after edge N when the FIFO was empty.
REQ-017 There SHALL be no combinational path from i_data to a_data or b_data.
REQ-018 A pop on port x SHALL occur when x_valid && x_ready at a clk edge, advancing x_data to the next entry or deasserting x_valid.
REQ-019 x_valid SHALL be 1 exactly when occupancy_x > 0.
REQ-020 x_data SHALL be held stable while x_valid=1 and x_ready=0.
REQ-021 A simultaneous push and pop on the same FIFO at occupancy 1 SHALL leave occupancy at 1, with the new word becoming head.
REQ-022 A push to one port and a pop on the other port in the same cycle SHALL be independent of each other.
REQ-023 Per-FIFO occupancy SHALL take only the states EMPTY(0), ONE(1) and FULL(2).
REQ-024 Occupancy transitions SHALL be: push-only +1; pop-only -1; both or neither unchanged.
REQ-025 Pop on EMPTY SHALL be impossible, because x_valid=0 in that state.
REQ-026 Word order SHALL be preserved per port; no ordering is defined between ports.
REQ-027 a_cnt and b_cnt SHALL increment by 1 on each push to their own port.
REQ-028 a_cnt and b_cnt SHALL wrap modulo 2^16, going from 0xFFFF to 0x0000.
REQ-029 When i_valid=0, no push and no counter change SHALL occur, regardless of i_sel.
REQ-030 Changing i_sel while i_valid=1 and i_ready=0 is legal; the word SHALL be accepted on whichever port first has room under the current i_sel.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for clk, force:
  - occupancy A and B to EMPTY
  - a_valid = b_valid = 0
  - a_cnt = b_cnt = 0
  - a_data = b_data = 32'h0
REQ-032 While rst=1, i_ready SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered words.
REQ-034 The first push after reset deassertion SHALL be allowed at the first clk edge where rst=0.

Verification
REQ-035 Reset: assert rst asynchronously between edges -> all outputs reach their REQ-031 values before the next edge; i_ready=0.
REQ-036 Routing: push 0x11111111 with i_sel=1, then 0x22222222 with i_sel=0 -> a_data=0x11111111 and b_data=0x22222222 one cycle after each push; a_cnt=1, b_cnt=1.
REQ-037 Backpressure full: a_ready=0, push 3 words to A -> first two accepted, i_ready=0 on the third while i_sel=1.
REQ-037a Then drive i_sel=0 in the same scenario -> i_ready=1.
REQ-038 Order and stall: A FIFO full, hold a_ready=0 for 5 cycles -> a_data stable.
REQ-038a Then drive a_ready=1 -> words pop in push order, then a_valid=0.
REQ-039 Simultaneous: A at ONE, push to A and pop A in the same cycle -> occupancy stays ONE and a_data is the new word.
REQ-039a Separately, push to B while popping A -> occupancies update independently.
REQ-040 Wrap: perform 65536 pushes to B -> b_cnt returns to 0x0000 and a_cnt is unchanged.

Source files
------------

// File: rtl/demux1to2_32_buf.sv
// -----------------------------------------------------------------------------
// demux1to2_32_buf
//
// Routes 32-bit words from a single valid/ready source to one of two
// destination ports. Each destination owns an independent 2-entry FIFO, and
// each port keeps a 16-bit count of the words accepted for it.
//
// Ports
//   clk              rising-edge clock for all state
//   rst              asynchronous, active-high reset
//   i_data  [31:0]   word offered by the upstream source
//   i_sel            destination select: 1 -> port A, 0 -> port B
//   i_valid          upstream word valid
//   i_ready          selected FIFO has room (0 while rst is high)
//   a_data  [31:0]   head word of FIFO A (registered)
//   a_valid          FIFO A non-empty
//   a_ready          downstream A consumes the head word
//   b_data/b_valid/b_ready   same as above, for port B
//   a_cnt/b_cnt [15:0]       words accepted per port, wrapping modulo 2^16
// -----------------------------------------------------------------------------

// Two-entry in-order FIFO. The head word comes straight from storage, so
// nothing combinational links the write data to the read data.
module demux1to2_32_buf_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        ready,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        full
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t        occ_q;
  occ_t        occ_d;
  logic [31:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        pop;

  assign valid = (occ_q != EMPTY);
  assign full  = (occ_q == FULL);
  assign pop   = valid && ready;
  assign rdata = mem[rd_ptr];

  // NOTE: always_ff blocks use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= EMPTY;
    else     occ_q <= occ_d;
  end

  // Push with pop (or neither) leaves occupancy unchanged. The parent never
  // pushes into FULL, and pop implies non-EMPTY.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when new cases are added later.
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = (occ_q == EMPTY) ? ONE : FULL;
      2'b01:   occ_d = (occ_q == FULL)  ? ONE : EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // When both happen at occupancy ONE, the write lands in the slot that the
  // read pointer advances to, so the new word becomes the head.
  // NOTE: the storage is reset because the head word is a visible output that
  // must read as zero during and right after reset; with only two entries
  // this costs nothing that matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= 32'h0;
      mem[1] <= 32'h0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

module demux1to2_32_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data,
  input  logic        i_sel,
  input  logic        i_valid,
  output logic        i_ready,
  output logic [31:0] a_data,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] b_data,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [15:0] a_cnt,
  output logic [15:0] b_cnt
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // Room is judged on registered occupancy only: a FULL FIFO refuses a word
  // even in the cycle it pops, which keeps i_ready free of any path from the
  // downstream ready inputs.
  assign i_ready = !rst && (i_sel ? !full_a : !full_b);
  assign push_a  = i_valid && i_ready &&  i_sel;
  assign push_b  = i_valid && i_ready && !i_sel;

  demux1to2_32_buf_fifo u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .wdata (i_data),
    .ready (a_ready),
    .rdata (a_data),
    .valid (a_valid),
    .full  (full_a)
  );

  demux1to2_32_buf_fifo u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .wdata (i_data),
    .ready (b_ready),
    .rdata (b_data),
    .valid (b_valid),
    .full  (full_b)
  );

  // Accepted-word counters wrap naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= 16'h0;
      b_cnt <= 16'h0;
    end else begin
      if (push_a) a_cnt <= a_cnt + 16'd1;
      if (push_b) b_cnt <= b_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux1to2_32_buf.sv
module tb_demux1to2_32_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        i_sel;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] a_cnt;
  logic [15:0] b_cnt;

  demux1to2_32_buf dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_sel   (i_sel),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .a_cnt   (a_cnt),
    .b_cnt   (b_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: one queue of expected words per port plus expected counts.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] ma_cnt;
  logic [15:0] mb_cnt;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("a_valid", 32'(a_valid), 32'(qa.size() > 0));
    check("b_valid", 32'(b_valid), 32'(qb.size() > 0));
    if (qa.size() > 0) check("a_data", a_data, qa[0]);
    if (qb.size() > 0) check("b_data", b_data, qb[0]);
    check("a_cnt", 32'(a_cnt), 32'(ma_cnt));
    check("b_cnt", 32'(b_cnt), 32'(mb_cnt));
  endtask

  // Reset values, checked while rst is high and a word is being offered.
  task automatic check_reset(input string tag);
    i_valid = 1'b1;
    i_sel   = 1'b1;
    #1;
    check({tag, "_i_ready"}, 32'(i_ready), 32'h0);
    check({tag, "_a_valid"}, 32'(a_valid), 32'h0);
    check({tag, "_b_valid"}, 32'(b_valid), 32'h0);
    check({tag, "_a_data"},  a_data,       32'h0);
    check({tag, "_b_data"},  b_data,       32'h0);
    check({tag, "_a_cnt"},   32'(a_cnt),   32'h0);
    check({tag, "_b_cnt"},   32'(b_cnt),   32'h0);
    i_valid = 1'b0;
    qa.delete();
    qb.delete();
    ma_cnt = 16'h0;
    mb_cnt = 16'h0;
  endtask

  // One clock cycle: drive at the falling edge, check before the rising edge,
  // then retire pops and pushes into the scoreboard at the rising edge.
  task automatic step(input logic v, input logic sel, input logic [31:0] d,
                      input logic ar, input logic br);
    logic exp_rdy;
    logic push;
    logic pop_a;
    logic pop_b;
    @(negedge clk);
    i_valid = v;
    i_sel   = sel;
    i_data  = d;
    a_ready = ar;
    b_ready = br;
    #1;
    exp_rdy = sel ? (qa.size() < 2) : (qb.size() < 2);
    check("i_ready", 32'(i_ready), 32'(exp_rdy));
    check_state();
    push  = v && exp_rdy;
    pop_a = ar && (qa.size() > 0);
    pop_b = br && (qb.size() > 0);
    @(posedge clk);
    if (pop_a) void'(qa.pop_front());
    if (pop_b) void'(qb.pop_front());
    if (push) begin
      if (sel) begin qa.push_back(d); ma_cnt++; end
      else     begin qb.push_back(d); mb_cnt++; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] b_before;
    logic [15:0] a_before;

    // Power-on reset, with the offered word ignored while rst is high.
    rst = 1'b1; i_data = 32'h0; i_sel = 1'b0; i_valid = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    #2;
    check_reset("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Routing; the first push lands on the first edge after deassertion.
    step(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
    check("route_a_data", a_data, 32'h1111_1111);
    check("route_b_data", b_data, 32'h2222_2222);
    check("route_a_cnt",  32'(a_cnt), 32'd1);
    check("route_b_cnt",  32'(b_cnt), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Backpressure: A fills, third word refused, then offered to B instead.
    step(1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hA000_0003, 1'b0, 1'b0);
    check("full_i_ready", 32'(i_ready), 32'h0);
    step(1'b1, 1'b1, 32'hA000_0003, 1'b1, 1'b0);  // full refuses while popping
    step(1'b1, 1'b1, 32'hA000_0004, 1'b0, 1'b0);  // refill to FULL
    step(1'b1, 1'b0, 32'hB000_0003, 1'b0, 1'b0);  // sel flips, B accepts
    check("sel_flip_i_ready", 32'(i_ready), 32'h1);

    // Stall: A stays FULL for 5 cycles, head must not move.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    check("stall_a_data", a_data, 32'hA000_0002);
    // Drain A in order, then a_valid drops.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    check("drain_a_valid", 32'(a_valid), 32'h0);

    // Simultaneous push and pop at ONE: new word becomes head.
    step(1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hC000_0002, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0,         1'b0, 1'b0);
    check("simul_a_data",  a_data,       32'hC000_0002);
    check("simul_i_ready", 32'(i_ready), 32'h1);  // still ONE, not FULL
    // Push B while popping A.
    step(1'b1, 1'b0, 32'hD000_0001, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
    check("cross_a_valid", 32'(a_valid), 32'h0);

    // Mid-operation async reset discards buffered words.
    step(1'b1, 1'b1, 32'hE000_0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hE000_0002, 1'b0, 1'b0);
    #2 rst = 1'b1;
    check_reset("mid");
    @(posedge clk);
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0,         1'b1, 1'b0);

    // Counter wrap: 65536 pushes to B while B drains every cycle.
    a_before = ma_cnt;
    b_before = mb_cnt;
    for (int k = 0; k < 65536; k++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_b_cnt", 32'(b_cnt), 32'(b_before));
    check("wrap_a_cnt", 32'(a_cnt), 32'(a_before));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
